// File: rtl/slow_data_memory.sv
// slow_data_memory: word memory that finishes every access a fixed LATENCY cycles after accepting it.
//   clk, rst              clock (rising edge) and asynchronous active-low reset
//   mem_read, mem_write   request strobes; the master holds them until mem_ready
//   mem_addr, mem_wdata   word address and write data, latched when the request is accepted
//   mem_rdata             read data; holds its value until the next read completes
//   mem_ready             one-cycle completion pulse
//   tap_wen/addr/data     write-commit strobe plus the committed address and data
//   err                   sticky protocol error (read+write together, or address out of range)
//   rd_count, wr_count    saturating counters of completed reads and writes
module slow_data_memory #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [29:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        tap_wen,
   output logic [29:0] tap_addr,
   output logic [31:0] tap_data,
   output logic        err,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        op_wr;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;
   logic [29:0] tap_addr_q;
   logic [31:0] tap_data_q;
   logic [31:0] rd_word;
   logic        accept, resp, in_range;
   assign accept   = state == IDLE && (mem_read || mem_write);
   assign resp     = state == RESP;
   assign in_range = addr_q < 30'(DEPTH);
   assign rd_word  = in_range ? mem[addr_q[AW-1:0]] : '0;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: if (accept) begin
            state_nx = LATENCY == 1 ? RESP : WAIT;
            cnt_nx   = LATENCY == 1 ? 4'd0 : 4'(LATENCY - 2);
         end
         WAIT: if (cnt == 4'd0) state_nx = RESP;
               else cnt_nx = cnt - 4'd1;
         default: state_nx = IDLE;
      endcase
   end
   // Completion-cycle values are driven straight from the latched request; the
   // hold registers keep them visible afterwards.
   assign mem_ready = resp;
   assign tap_wen   = resp && op_wr;
   assign mem_rdata = (resp && !op_wr) ? rd_word : rdata_q;
   assign tap_addr  = tap_wen ? addr_q : tap_addr_q;
   assign tap_data  = tap_wen ? wdata_q : tap_data_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         op_wr      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err        <= 1'b0;
         rdata_q    <= '0;
         tap_addr_q <= '0;
         tap_data_q <= '0;
         rd_count   <= '0;
         wr_count   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            op_wr   <= mem_write;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            if ((mem_read && mem_write) || mem_addr >= 30'(DEPTH)) err <= 1'b1;
         end
         if (resp && op_wr) begin
            tap_addr_q <= addr_q;
            tap_data_q <= wdata_q;
            wr_count   <= wr_count == 16'hFFFF ? wr_count : wr_count + 16'd1;
         end
         if (resp && !op_wr) begin
            rdata_q  <= rd_word;
            rd_count <= rd_count == 16'hFFFF ? rd_count : rd_count + 16'd1;
         end
      end
   end
   // Array commits at the edge that ends a write's completion cycle; out-of-range writes are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (resp && op_wr && in_range) begin
         mem[addr_q[AW-1:0]] <= wdata_q;
      end
   end
endmodule

// File: doc/slow_data_memory.md
SLOW_DATA_MEMORY -- requirements
Module: slow_data_memory

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of 32-bit words stored; valid word addresses are 0..DEPTH-1.
REQ-002 Parameter LATENCY, default 4, SHALL set the cycle count from request acceptance to mem_ready; legal range 1..15.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mem_read  input  1  word read request, held by the master until mem_ready.
REQ-006 mem_write  input  1  word write request, held by the master until mem_ready.
REQ-007 mem_addr  input  30  word address.
REQ-008 mem_wdata  input  32  write data, stored as presented (little-endian byte order, no swapping).
REQ-009 mem_rdata  output  32  read data.
REQ-010 mem_ready  output  1  one-cycle completion pulse.
REQ-011 tap_wen  output  1  write-commit strobe for the downstream write monitor.
REQ-012 tap_addr  output  30  committed write address.
REQ-013 tap_data  output  32  committed write data.
REQ-014 err  output  1  sticky protocol error.
REQ-015 rd_count, wr_count  output  16 each  completed-access counters.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-017 In IDLE, mem_read or mem_write high SHALL accept the request: latch op, mem_addr and mem_wdata, then go to RESP if LATENCY=1, else go to WAIT with the counter loaded to LATENCY-2.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-019 Request present in cycle c in IDLE -> mem_ready SHALL be high exactly in cycle c+LATENCY, for one cycle (RESP).
REQ-020 RESP SHALL always go to IDLE next cycle, so back-to-back accesses are spaced LATENCY+1 cycles apart.
REQ-021 Input changes after acceptance SHALL be ignored until the FSM returns to IDLE.
REQ-022 Read in RESP: mem_rdata SHALL equal the array word at the latched address; it SHALL hold until the next read reaches RESP.
REQ-023 Write in RESP: tap_wen=1, tap_addr/tap_data = latched values for that cycle only; the array SHALL update at the edge ending RESP.
REQ-024 tap_wen SHALL be 0 in all other cycles; tap_addr and tap_data SHALL hold their last values.
REQ-025 mem_read and mem_write both high at acceptance: the access SHALL be performed as a write and err SHALL be set.
REQ-026 Latched address >= DEPTH: a write SHALL be dropped (no array update, tap_wen still pulses); a read SHALL return 0; err SHALL be set; mem_ready timing is unchanged.
REQ-027 Each RESP SHALL increment rd_count or wr_count by 1, saturating at 16'hFFFF.
REQ-028 err SHALL be cleared only by reset.

Reset
REQ-029 rst low SHALL immediately force IDLE, counter=0, and mem_ready, tap_wen, err, mem_rdata, tap_addr, tap_data, rd_count and wr_count to 0, and clear all array words to 0.
REQ-030 Reset during WAIT or RESP SHALL abort the access with no array update and no mem_ready or tap_wen pulse.
REQ-031 On the first edge after rst rises, the block SHALL be in IDLE and able to accept a request.

Verification
REQ-032 LATENCY=4; write addr 5, data 32'h11223344, held from cycle 0 -> mem_ready and tap_wen high in cycle 4 only; tap_addr=5; tap_data=32'h11223344; wr_count=1.
REQ-033 Then read addr 5 from cycle 5 -> mem_ready high in cycle 9; mem_rdata=32'h11223344; rd_count=1; tap_wen stays 0.
REQ-034 LATENCY=1; read addr 0 after reset -> mem_ready high in the next cycle; mem_rdata=0.
REQ-035 Write addr 300 (DEPTH=256), data 32'hDEADBEEF -> mem_ready and tap_wen pulse on time; err=1; a following read of addr 44 (300 mod 256) returns 0.
REQ-036 mem_read and mem_write high together, addr 7, data 32'hA5A5A5A5 -> a write is performed; err=1; a read of addr 7 returns 32'hA5A5A5A5.
REQ-037 Write to addr 3 with rst pulsed low during WAIT -> no mem_ready or tap_wen; a read of addr 3 after reset returns 0; all counters are 0.
